// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for a single shared IO port.
// One transaction in flight: grant, issue one io_en cycle, ack the owner.
module io_bus_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] io_addr,
  output logic              io_en,
  output logic              io_we,
  output logic [DATA_W-1:0] io_data_write,
  input  logic [DATA_W-1:0] io_data_read,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic              last_grant;
  logic              we_q;
  logic              any_req;
  logic              win;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // On contention the master that did not win last time gets the bus.
  always_comb begin
    any_req = m0_req | m1_req;
    win     = (m0_req & m1_req) ? ~last_grant : m1_req;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      we_q          <= 1'b0;
      io_addr       <= '0;
      io_data_write <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        owner         <= win;
        last_grant    <= win;
        we_q          <= win ? m1_we : m0_we;
        io_addr       <= win ? m1_addr : m0_addr;
        io_data_write <= win ? m1_wdata : m0_wdata;
      end
      if (state == DONE) begin
        if (owner) rdata1_q <= io_data_read;
        else       rdata0_q <= io_data_read;
      end
    end
  end

  // Read data shows through during the ack cycle, then stays captured.
  always_comb begin
    io_en    = (state == ISSUE);
    io_we    = io_en & we_q;
    busy     = (state != IDLE);
    m0_ack   = (state == DONE) & ~owner;
    m1_ack   = (state == DONE) &  owner;
    m0_rdata = m0_ack ? io_data_read : rdata0_q;
    m1_rdata = m1_ack ? io_data_read : rdata1_q;
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-timing reference model.
module tb_io_bus_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req, m0_we, m0_ack;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_ack;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] io_addr;
  logic          io_en, io_we, busy, owner;
  logic [DW-1:0] io_data_write;
  logic [DW-1:0] io_data_read = '0;

  always #5 clk = ~clk;

  bit          req [2];
  bit          we  [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wd   [2];
  bit          pend [2];

  assign m0_req   = req[0];
  assign m0_we    = we[0];
  assign m0_addr  = addr[0];
  assign m0_wdata = wd[0];
  assign m1_req   = req[1];
  assign m1_we    = we[1];
  assign m1_addr  = addr[1];
  assign m1_wdata = wd[1];

  io_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .io_addr(io_addr), .io_en(io_en), .io_we(io_we),
    .io_data_write(io_data_write), .io_data_read(io_data_read),
    .busy(busy), .owner(owner)
  );

  // Reference: a grant at cycle t_g means io_en at t_g+1, ack at t_g+2,
  // and the port is free again from t_g+3.
  int            cyc;
  int            t_g;
  bit            own;
  bit            last;
  logic [AW-1:0] l_addr;
  bit            l_we;
  logic [DW-1:0] l_wd;
  logic [DW-1:0] rd [2];
  bit            ack_seen [2];

  int n_vec = 0;
  int n_bad = 0;
  bit chk = 0;
  int p_new = 0;
  int p_drop = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    t_g = -1000;
    own = 0;
    last = 1;
    l_addr = '0;
    l_we = 0;
    l_wd = '0;
    rd[0] = '0;
    rd[1] = '0;
    ack_seen[0] = 0;
    ack_seen[1] = 0;
  endtask

  task automatic raise(input int m);
    pend[m] = 1;
    req[m]  = 1;
    we[m]   = 1'($urandom);
    addr[m] = AW'($urandom);
    wd[m]   = $urandom;
  endtask

  task automatic clear_masters();
    for (int m = 0; m < 2; m++) begin
      req[m] = 0;
      pend[m] = 0;
    end
  endtask

  task automatic drive();
    for (int m = 0; m < 2; m++) begin
      if (ack_seen[m]) begin
        ack_seen[m] = 0;
        req[m] = 0;
        pend[m] = 0;
      end
      if (!pend[m] && $urandom_range(99) < p_new) raise(m);
      if (pend[m] && req[m] && cyc == t_g + 1 && int'(own) == m &&
          $urandom_range(99) < p_drop)
        req[m] = 0;
    end
    io_data_read = $urandom;
  endtask

  task automatic tick();
    bit issue, done;
    int w;
    issue = (cyc == t_g + 1);
    done  = (cyc == t_g + 2);
    #1;
    if (chk) begin
      check("io_en", io_en, issue);
      check("io_we", io_we, issue & l_we);
      check("io_addr", io_addr, l_addr);
      check("io_data_write", io_data_write, l_wd);
      check("busy", busy, issue | done);
      check("owner", owner, own);
      check("m0_ack", m0_ack, done && !own);
      check("m1_ack", m1_ack, done && own);
      check("m0_rdata", m0_rdata, (done && !own) ? io_data_read : rd[0]);
      check("m1_rdata", m1_rdata, (done && own) ? io_data_read : rd[1]);
    end
    if (reset) begin
      model_reset();
    end else begin
      if (done) begin
        rd[own] = io_data_read;
        ack_seen[own] = 1;
      end
      if (cyc >= t_g + 3 && (req[0] || req[1])) begin
        w = (req[0] && req[1]) ? int'(!last) : int'(req[1]);
        t_g = cyc;
        own = w[0];
        last = w[0];
        l_addr = addr[w];
        l_we = we[w];
        l_wd = wd[w];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      tick();
    end
  endtask

  task automatic reset_cycle();
    drive();
    reset = 1;
    tick();
    reset = 0;
    clear_masters();
  endtask

  initial begin
    cyc = 0;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      req[m] = 0; we[m] = 0; addr[m] = '0; wd[m] = '0; pend[m] = 0;
    end
    reset = 1;
    tick();
    chk = 1;
    tick();
    reset = 0;

    // m0 read of 0x10
    raise(0); we[0] = 0; addr[0] = 8'h10;
    run(5);
    // m1 write of 0xA5 to 0x04
    raise(1); we[1] = 1; addr[1] = 8'h04; wd[1] = 32'hA5;
    run(5);

    // continuous contention from reset: m0, m1, m0, m1
    reset_cycle();
    p_new = 100;
    raise(0); raise(1);
    run(13);
    p_new = 0;
    run(4);
    clear_masters();

    // m1 arrives while m0 is in ISSUE
    raise(0);
    run(2);
    raise(1);
    run(7);

    // reset in the ISSUE cycle aborts; next contention goes to m0
    raise(0); raise(1);
    drive();
    tick();
    reset_cycle();
    raise(0); raise(1);
    run(8);

    // owner drops req during ISSUE, still acked
    p_drop = 100;
    raise(0);
    run(5);
    raise(1);
    run(5);

    // random traffic
    p_new = 30;
    p_drop = 10;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) reset_cycle();
      else run(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, 8, IO address width; DATA_W, 32, IO data width.
REQ-002 SHALL have ports (name, direction, width, meaning): clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 reset, input, 1, synchronous active-high reset.
REQ-004 m0_req, m0_we, input, 1 each, master 0 (CPU core) request / write-enable.
REQ-005 m0_addr, input, ADDR_W; m0_wdata, input, DATA_W; master 0 address / write data.
REQ-006 m0_ack, output, 1; m0_rdata, output, DATA_W; master 0 completion pulse / read data.
REQ-007 m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, same widths and directions as the m0 set, master 1 (debug/DMA).
REQ-008 io_addr, output, ADDR_W; io_en, output, 1; io_we, output, 1; io_data_write, output, DATA_W; shared IO-port request bus.
REQ-009 io_data_read, input, DATA_W, IO-port read data, valid the cycle after io_en.
REQ-010 busy, output, 1, high in any state other than IDLE; owner, output, 1, index of the master owning the current transaction.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, DONE; exactly one IO transaction in flight.
REQ-012 IDLE: no req -> stay IDLE; any req -> latch the winner's addr/we/wdata and owner index, go to ISSUE.
REQ-013 Arbitration: single requester wins; both requesting -> master != last_grant wins (round-robin); last_grant updates on every grant.
REQ-014 ISSUE: io_en=1 for exactly this one cycle; io_addr/io_we/io_data_write driven from the latched values; then go to DONE.
REQ-015 DONE: ack of the owner =1 for exactly one cycle; rdata of the owner = io_data_read (registered capture, held until that master's next ack); then go to IDLE.
REQ-016 Latency: req first seen in IDLE at cycle T -> io_en at T+1 -> ack at T+2 -> IDLE at T+3; minimum 3 cycles per transaction.
REQ-017 Masters SHALL hold req, we, addr, wdata stable until ack and drop req on the edge ending the ack cycle; req still high at T+3 is a new request.
REQ-018 req deasserted or changed after the grant is ignored; the latched transaction completes and is acked.
REQ-019 Request from the non-owner during ISSUE/DONE waits in IDLE; it is not dropped.
REQ-020 Both masters requesting continuously SHALL alternate grants with no master starved beyond one transaction.
REQ-021 Outside ISSUE: io_en=0 and io_we=0; io_addr/io_data_write hold their last latched values.
REQ-022 Write transactions still ack in DONE; rdata is updated with io_data_read on writes as well (value don't-care to masters).
REQ-023 The non-owner's ack SHALL never assert; at most one ack is high per cycle.

Reset
REQ-024 reset=1 at any edge -> state IDLE, io_en=0, io_we=0, m0_ack=m1_ack=0, busy=0, owner=0, last_grant=1 (first contention goes to m0), io_addr=0, io_data_write=0, m0_rdata=m1_rdata=0.
REQ-025 Reset mid-transaction aborts it with no ack; an io_en already issued is not retracted; reset has priority over all transitions.

Verification
REQ-026 m0 read addr 0x10, io_data_read=0xDEADBEEF at T+2 -> io_en=1,io_we=0,io_addr=0x10 at T+1; m0_ack=1, m0_rdata=0xDEADBEEF at T+2; m1_ack stays 0.
REQ-027 m1 write addr 0x04 data 0x000000A5 -> io_en=1,io_we=1,io_addr=0x04,io_data_write=0xA5 at T+1; m1_ack at T+2; busy high T+1..T+2.
REQ-028 After reset, both req high continuously for 4 transactions -> owners in order m0,m1,m0,m1; acks at T+2, T+5, T+8, T+11.
REQ-029 m0 granted, m1 req raised during ISSUE -> m0 completes; m1 granted at T+3, io_en at T+4, m1_ack at T+5.
REQ-030 reset asserted in ISSUE cycle -> next cycle IDLE, io_en=0, busy=0, no ack ever for that transaction; next contention won by m0.
REQ-031 m0 drops req during ISSUE -> m0_ack still pulses at T+2; exactly one io_en per grant in all scenarios.
